// File: rtl/load_writeback_unit.sv
// In-order load writeback queue: tracks outstanding loads, formats returned memory
// words into register-file writes and reports pending-load hazards to decode.
module load_writeback_unit #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             issue_valid,
  output logic                             issue_ready,
  input  logic [REG_ADDR_WIDTH-1:0]        issue_rd,
  input  logic [2:0]                       issue_funct3,
  input  logic [1:0]                       issue_addr_lo,
  input  logic                             mem_resp_valid,
  input  logic [31:0]                      mem_resp_data,
  output logic                             rf_write_enable,
  output logic [REG_ADDR_WIDTH-1:0]        rf_write_reg_addr,
  output logic [31:0]                      rf_write_data,
  output logic [3:0]                       rf_write_width,
  input  logic [REG_ADDR_WIDTH-1:0]        query_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]        query_rs2,
  output logic                             hazard_rs1,
  output logic                             hazard_rs2,
  output logic [$clog2(QUEUE_DEPTH):0]     pending_count,
  output logic                             issue_exception,
  output logic                             resp_error
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_ADDR_WIDTH-1:0] r_rd [QUEUE_DEPTH];
  logic [2:0]                r_f3 [QUEUE_DEPTH];
  logic [1:0]                r_lo [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]    r_valid;
  logic [PTR_W-1:0]          r_head;
  logic [PTR_W-1:0]          r_tail;
  logic [CNT_W-1:0]          r_count;
  logic                      r_we;
  logic [REG_ADDR_WIDTH-1:0] r_waddr;
  logic [31:0]               r_wdata;
  logic [3:0]                r_wwidth;
  logic                      r_exc;
  logic                      r_err;

  logic                      w_empty;
  logic                      w_full;
  logic                      w_illegal;
  logic                      w_misaligned;
  logic                      w_accept;
  logic                      w_push;
  logic                      w_pop;
  logic [REG_ADDR_WIDTH-1:0] w_head_rd;
  logic [2:0]                w_head_f3;
  logic [1:0]                w_head_lo;
  logic [7:0]                w_byte;
  logic [15:0]               w_half;
  logic [31:0]               w_data;
  logic [3:0]                w_width;
  logic                      w_hit1;
  logic                      w_hit2;

  assign w_empty      = (r_count == {CNT_W{1'b0}});
  assign w_full       = (r_count == CNT_W'(QUEUE_DEPTH));
  assign w_illegal    = (issue_funct3 == 3'b011) || (issue_funct3 == 3'b110) ||
                        (issue_funct3 == 3'b111);
  assign w_misaligned = (((issue_funct3 == 3'b001) || (issue_funct3 == 3'b101)) && issue_addr_lo[0]) ||
                        ((issue_funct3 == 3'b010) && (issue_addr_lo != 2'b00));
  // No pop bypass: a full queue refuses issues even while a response drains it.
  assign w_accept     = issue_valid && !w_full;
  assign w_push       = w_accept && !w_illegal && !w_misaligned;
  assign w_pop        = mem_resp_valid && !w_empty;

  assign w_head_rd = r_rd[r_head];
  assign w_head_f3 = r_f3[r_head];
  assign w_head_lo = r_lo[r_head];

  // Byte/half lane selection from the aligned response word
  always_comb begin
    w_byte = 8'h00;
    w_half = mem_resp_data[15:0];
    case (w_head_lo)
      2'b00:   w_byte = mem_resp_data[7:0];
      2'b01:   w_byte = mem_resp_data[15:8];
      2'b10:   w_byte = mem_resp_data[23:16];
      2'b11:   w_byte = mem_resp_data[31:24];
      default: w_byte = 8'h00;
    endcase
    if (w_head_lo[1]) begin
      w_half = mem_resp_data[31:16];
    end else begin
      w_half = mem_resp_data[15:0];
    end
  end

  // Sign/zero extension and width code by load type
  always_comb begin
    w_data  = mem_resp_data;
    w_width = 4'd4;
    case (w_head_f3)
      3'b000:  begin w_data = {{24{w_byte[7]}}, w_byte}; w_width = 4'd1; end
      3'b001:  begin w_data = {{16{w_half[15]}}, w_half}; w_width = 4'd2; end
      3'b100:  begin w_data = {24'h000000, w_byte};       w_width = 4'd1; end
      3'b101:  begin w_data = {16'h0000, w_half};         w_width = 4'd2; end
      default: begin w_data = mem_resp_data;              w_width = 4'd4; end
    endcase
  end

  // Pending-load hazard search over valid entries
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      w_hit1 = w_hit1 | (r_valid[i] && (r_rd[i] == query_rs1));
      w_hit2 = w_hit2 | (r_valid[i] && (r_rd[i] == query_rs2));
    end
  end

  // Queue state, writeback port and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= {QUEUE_DEPTH{1'b0}};
      r_head   <= {PTR_W{1'b0}};
      r_tail   <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_we     <= 1'b0;
      r_waddr  <= {REG_ADDR_WIDTH{1'b0}};
      r_wdata  <= 32'h0000_0000;
      r_wwidth <= 4'd0;
      r_exc    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_rd[r_tail]    <= issue_rd;
        r_f3[r_tail]    <= issue_funct3;
        r_lo[r_tail]    <= issue_addr_lo;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
        r_waddr         <= w_head_rd;
        r_wdata         <= w_data;
        r_wwidth        <= w_width;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_we  <= w_pop && (w_head_rd != {REG_ADDR_WIDTH{1'b0}});
      r_exc <= w_accept && (w_illegal || w_misaligned);
      r_err <= r_err || (mem_resp_valid && w_empty);
    end
  end

  assign issue_ready       = !w_full;
  assign pending_count     = r_count;
  assign hazard_rs1        = (query_rs1 != {REG_ADDR_WIDTH{1'b0}}) && w_hit1;
  assign hazard_rs2        = (query_rs2 != {REG_ADDR_WIDTH{1'b0}}) && w_hit2;
  assign rf_write_enable   = r_we;
  assign rf_write_reg_addr = r_waddr;
  assign rf_write_data     = r_wdata;
  assign rf_write_width    = r_wwidth;
  assign issue_exception   = r_exc;
  assign resp_error        = r_err;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Bench for load_writeback_unit: directed scenarios then random traffic, all
// checked against a queue-based reference model of the load semantics.
module tb_load_writeback_unit;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_rd = 5'd0;
  logic [2:0]  issue_funct3 = 3'd0;
  logic [1:0]  issue_addr_lo = 2'd0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'd0;
  logic        rf_write_enable;
  logic [4:0]  rf_write_reg_addr;
  logic [31:0] rf_write_data;
  logic [3:0]  rf_write_width;
  logic [4:0]  query_rs1 = 5'd0;
  logic [4:0]  query_rs2 = 5'd0;
  logic        hazard_rs1;
  logic        hazard_rs2;
  logic [2:0]  pending_count;
  logic        issue_exception;
  logic        resp_error;

  load_writeback_unit #(.QUEUE_DEPTH(QD), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .issue_funct3(issue_funct3), .issue_addr_lo(issue_addr_lo),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .rf_write_enable(rf_write_enable), .rf_write_reg_addr(rf_write_reg_addr),
    .rf_write_data(rf_write_data), .rf_write_width(rf_write_width),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
    .pending_count(pending_count), .issue_exception(issue_exception),
    .resp_error(resp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rd;
    int f3;
    int lo;
  } ent_t;

  ent_t m_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic        e_we = 1'b0;
  logic [31:0] e_addr = 32'd0;
  logic [31:0] e_data = 32'd0;
  logic [31:0] e_width = 32'd0;
  logic        e_exc = 1'b0;
  logic        e_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit m_haz(input int r);
    if (r == 0) return 1'b0;
    foreach (m_q[i]) if (m_q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive, predict from the model, clock, compare.
  task automatic cycle(input bit iv, input int rd, input int f3, input int lo,
                       input bit rv, input logic [31:0] d, input bit rst);
    ent_t e;
    ent_t n;
    bit acc;
    bit bad;
    bit popped;
    logic [7:0]  b;
    logic [15:0] h;
    issue_valid    = iv;
    issue_rd       = 5'(rd);
    issue_funct3   = 3'(f3);
    issue_addr_lo  = 2'(lo);
    mem_resp_valid = rv;
    mem_resp_data  = d;
    reset          = rst;
    #1;
    chk("issue_ready", {31'd0, issue_ready}, {31'd0, m_q.size() < QD});
    popped = 1'b0;
    e_exc  = 1'b0;
    e_we   = 1'b0;
    if (rst) begin
      m_q.delete();
      e_addr = 0; e_data = 0; e_width = 0; e_err = 1'b0;
      popped = 1'b1;
    end else begin
      acc = iv && (m_q.size() < QD);
      bad = (f3 == 3 || f3 == 6 || f3 == 7) ||
            ((f3 == 1 || f3 == 5) && (lo % 2 == 1)) || (f3 == 2 && lo != 0);
      if (rv) begin
        if (m_q.size() == 0) begin
          e_err = 1'b1;
        end else begin
          e = m_q.pop_front();
          popped = 1'b1;
          e_we   = (e.rd != 0);
          e_addr = 32'(e.rd);
          b = d[8*e.lo +: 8];
          h = d[16*(e.lo/2) +: 16];
          case (e.f3)
            0:       begin e_data = {{24{b[7]}}, b};  e_width = 1; end
            4:       begin e_data = {24'd0, b};       e_width = 1; end
            1:       begin e_data = {{16{h[15]}}, h}; e_width = 2; end
            5:       begin e_data = {16'd0, h};       e_width = 2; end
            default: begin e_data = d;                e_width = 4; end
          endcase
        end
      end
      if (acc && bad) e_exc = 1'b1;
      else if (acc) begin
        n.rd = rd; n.f3 = f3; n.lo = lo;
        m_q.push_back(n);
      end
    end
    @(posedge clk);
    #1;
    chk("write_enable", {31'd0, rf_write_enable}, {31'd0, e_we});
    if (popped) begin
      chk("write_addr", {27'd0, rf_write_reg_addr}, e_addr);
      chk("write_data", rf_write_data, e_data);
      chk("write_width", {28'd0, rf_write_width}, e_width);
    end
    chk("issue_exception", {31'd0, issue_exception}, {31'd0, e_exc});
    chk("resp_error", {31'd0, resp_error}, {31'd0, e_err});
    chk("pending_count", {29'd0, pending_count}, 32'(m_q.size()));
    chk("hazard_rs1", {31'd0, hazard_rs1}, {31'd0, m_haz(int'(query_rs1))});
    chk("hazard_rs2", {31'd0, hazard_rs2}, {31'd0, m_haz(int'(query_rs2))});
  endtask

  task automatic idle();
    cycle(1'b0, 0, 0, 0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst_count", {29'd0, pending_count}, 32'd0);
    chk("rst_we", {31'd0, rf_write_enable}, 32'd0);
    chk("rst_data", rf_write_data, 32'd0);
    chk("rst_err", {31'd0, resp_error}, 32'd0);
    reset = 1'b0;
    idle();

    // LB with sign extension from the top byte lane
    query_rs1 = 5'd5; query_rs2 = 5'd9;
    cycle(1'b1, 5, 0, 3, 1'b0, 32'd0, 1'b0);
    chk("lb_hazard", {31'd0, hazard_rs1}, 32'd1);
    cycle(1'b0, 0, 0, 0, 1'b1, 32'h80FF_1234, 1'b0);
    chk("lb_data", rf_write_data, 32'hFFFF_FF80);
    chk("lb_width", {28'd0, rf_write_width}, 32'd1);
    idle();

    // Two loads to the same rd keep the hazard until the youngest pops
    query_rs1 = 5'd7;
    cycle(1'b1, 7, 5, 2, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 7, 2, 0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 0, 0, 0, 1'b1, 32'hBEEF_0001, 1'b0);
    chk("lhu_data", rf_write_data, 32'h0000_BEEF);
    chk("lhu_hazard_held", {31'd0, hazard_rs1}, 32'd1);
    cycle(1'b0, 0, 0, 0, 1'b1, 32'h1234_5678, 1'b0);
    chk("lw_hazard_drop", {31'd0, hazard_rs1}, 32'd0);

    // Fill, overflow attempt, simultaneous pop/issue while full, drain
    for (int i = 1; i <= 4; i++) cycle(1'b1, i, 2, 0, 1'b0, 32'd0, 1'b0);
    chk("full_count", {29'd0, pending_count}, 32'd4);
    chk("full_ready", {31'd0, issue_ready}, 32'd0);
    cycle(1'b1, 9, 2, 0, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 10, 2, 0, 1'b1, 32'hCAFE_0001, 1'b0);
    chk("full_popissue", {29'd0, pending_count}, 32'd3);
    cycle(1'b1, 11, 4, 1, 1'b0, 32'd0, 1'b0);
    chk("refill_count", {29'd0, pending_count}, 32'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 0, 0, 1'b1, 32'hA5C3_96F0 + 32'(i), 1'b0);

    // Misaligned LW, illegal funct3, then a response while empty
    cycle(1'b1, 3, 2, 2, 1'b0, 32'd0, 1'b0);
    chk("misalign_exc", {31'd0, issue_exception}, 32'd1);
    idle();
    cycle(1'b1, 3, 3, 0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 0, 0, 0, 1'b1, 32'h0000_0042, 1'b0);
    chk("empty_resp_err", {31'd0, resp_error}, 32'd1);
    idle();

    // rd=0 consumes without writing; reset discards pending entries
    cycle(1'b1, 0, 2, 0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 0, 0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("rd0_noWrite", {31'd0, rf_write_enable}, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 12 + i, 1, 2, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 15, 0, 0, 1'b1, 32'd1, 1'b1);
    chk("reset_count", {29'd0, pending_count}, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0, 0, 1'b1, 32'd7, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      query_rs1 = 5'($urandom_range(0, 7));
      query_rs2 = 5'($urandom_range(0, 7));
      cycle($urandom_range(0, 2) != 0, int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, $urandom(), $urandom_range(0, 80) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_writeback_unit.md
LOAD_WRITEBACK_UNIT -- requirements
Module: load_writeback_unit

Interface
REQ-001 Parameter QUEUE_DEPTH, default 4, number of outstanding load entries; power of 2, at least 2.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, register index width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 issue_valid  input  1  load issued this cycle.
REQ-006 issue_ready  output  1  unit can accept an issue; equals !full, with no same-cycle pop bypass.
REQ-007 issue_rd  input  REG_ADDR_WIDTH  destination register.
REQ-008 issue_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-009 issue_addr_lo  input  2  byte offset of the load address.
REQ-010 mem_resp_valid  input  1  memory returns a word; always accepted, no backpressure.
REQ-011 mem_resp_data  input  32  naturally aligned word containing the loaded data.
REQ-012 rf_write_enable, rf_write_reg_addr, rf_write_data[31:0], rf_write_width[3:0]  output  registered register-file write port; width codes are 1, 2 or 4.
REQ-013 query_rs1, query_rs2  input  REG_ADDR_WIDTH  decode source registers.
REQ-014 hazard_rs1, hazard_rs2  output  1  combinational: the queried register has a pending load.
REQ-015 pending_count  output  $clog2(QUEUE_DEPTH)+1  number of valid queue entries.
REQ-016 issue_exception  output  1  registered one-cycle pulse for an illegal or misaligned issue.
REQ-017 resp_error  output  1  sticky flag: a response arrived with the queue empty.

Function
REQ-018 An issue is accepted when issue_valid && issue_ready. Accepted legal issues enqueue {rd, funct3, addr_lo} at the tail, in order.
REQ-019 An issue is illegal when funct3 is 011, 110 or 111.
REQ-020 An issue is misaligned when it is LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0.
REQ-021 An illegal or misaligned issue, when issue_ready=1, is not enqueued; issue_exception=1 on the next cycle only.
REQ-022 An issue presented while issue_ready=0 is ignored, with no exception pulse.
REQ-023 mem_resp_valid with a non-empty queue pops the head entry. Response order equals issue order.
REQ-024 In the cycle after a pop, rf_write_* presents the result (latency 1); rf_write_enable is 0 in all other cycles.
REQ-025 Extraction selects lane mem_resp_data[8*addr_lo +: 8] for bytes and mem_resp_data[16*addr_lo[1] +: 16] for halves.
REQ-026 LB/LH sign-extend to 32 bits; LBU/LHU zero-extend to 32 bits; LW passes the word through.
REQ-027 rf_write_width is 1 for LB/LBU, 2 for LH/LHU, and 4 for LW.
REQ-028 A popped entry with rd=0 produces rf_write_enable=0 in the following cycle; the entry is still consumed.
REQ-029 mem_resp_valid with an empty queue is dropped and sets resp_error=1 until reset. This applies even if an issue is accepted in the same cycle.
REQ-030 When an issue and a response occur in the same cycle on a non-empty queue, the pop and push both happen and pending_count is unchanged.
REQ-031 Head and tail pointers wrap modulo QUEUE_DEPTH. Full means pending_count==QUEUE_DEPTH; empty means pending_count==0.
REQ-032 hazard_rsN = (query_rsN!=0) && (some valid queue entry has rd==query_rsN). Entries issued this cycle count from the next cycle.
REQ-033 The hazard for an rd drops in the cycle its last entry is popped. The following write cycle relies on register-file write bypass.
REQ-034 Multiple pending loads to the same rd keep the hazard asserted until the youngest entry is popped.

Reset
REQ-035 With reset high at a clock edge, the unit shall empty the queue and set pending_count=0, issue_ready=1 and hazard_rs1=hazard_rs2=0.
REQ-036 The same edge shall clear rf_write_enable, rf_write_reg_addr, rf_write_data, rf_write_width, issue_exception and resp_error to 0.
REQ-037 Reset mid-operation discards all pending entries and any pending write. Responses arriving after reset are treated per REQ-029.
REQ-038 Issues and responses presented in a cycle with reset high are ignored.

Verification
REQ-039 Issue LB rd=5, addr_lo=3; then response 0x80FF_1234 -> next cycle write_enable=1, addr=5, data=0xFFFF_FF80, width=1.
REQ-040 Issue LHU rd=7, addr_lo=2, and LW rd=7, addr_lo=0; hazard_rs1 (query 7) stays 1 after the first response. Response 0xBEEF_0001 -> data=0x0000_BEEF; then hazard drops on the second response.
REQ-041 Fill 4 entries -> issue_ready=0 and pending_count=4. A 5th issue is ignored; a response plus issue in the same cycle -> count 3, then 4 on the next accepted issue.
REQ-042 Issue LW with addr_lo=2 -> issue_exception pulses 1 cycle and pending_count stays 0. A response while empty -> resp_error=1 and remains set.
REQ-043 Issue LW rd=0, then response -> pending_count returns to 0 and write_enable stays 0. Assert reset with 3 entries pending -> count 0 and no writes follow.
